// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the pure lane-steering helpers used on the store and load paths.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // Byte-lane write strobe for a store of the given size at the given offset.
    function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                                input logic [1:0] offset);
        logic [3:0] base;
        case (funct3)
            F3_B:    base = 4'b0001;
            F3_H:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return (funct3 == F3_W) ? 4'b1111 : (base << offset);
    endfunction

    // Replicate right-aligned store data across every lane it could land in.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] wdata);
        case (funct3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Right-align the addressed bytes of a RAM word and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    return {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   return {24'h000000, shifted[7:0]};
            F3_HU:   return {16'h0000, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed requests into word-addressed
// RAM commands, extracts load data and faults illegal accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WORD_ADDR_WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_write,
    input  logic [2:0]                 i_req_funct3,
    input  logic [31:0]                i_req_addr,
    input  logic [31:0]                i_req_wdata,
    output logic                       o_resp_valid,
    output logic [31:0]                o_resp_rdata,
    output logic                       o_resp_fault,
    output logic                       o_mem_read_enable,
    output logic [WORD_ADDR_WIDTH-1:0] o_mem_read_addr,
    input  logic [31:0]                i_mem_read_data,
    output logic [3:0]                 o_mem_write_enable,
    output logic [WORD_ADDR_WIDTH-1:0] o_mem_write_addr,
    output logic [31:0]                o_mem_write_data
);

    lsu_state_e                 state_q,  state_d;
    logic [WORD_ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [3:0]                 wstrb_q,  wstrb_d;
    logic [31:0]                wdata_q,  wdata_d;
    logic                       rd_en_q,  rd_en_d;
    logic [2:0]                 funct3_q, funct3_d;
    logic [1:0]                 offset_q, offset_d;
    logic [31:0]                rdata_q,  rdata_d;
    logic                       fault_q,  fault_d;

    logic accept;
    logic illegal_f3;
    logic misaligned;
    logic out_of_range;
    logic req_fault;

    // Classify the incoming request; any fault suppresses the RAM command.
    always_comb begin
        if (i_req_write) begin
            illegal_f3 = !(i_req_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal_f3 = !(i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned   = ((i_req_funct3 == F3_H || i_req_funct3 == F3_HU) && i_req_addr[0])
                    || ((i_req_funct3 == F3_W) && (i_req_addr[1:0] != 2'b00));
        out_of_range = |(i_req_addr >> (WORD_ADDR_WIDTH + 2));
        req_fault    = illegal_f3 || misaligned || out_of_range;
    end

    assign o_req_ready = (state_q == S_IDLE) && clk_en;
    assign accept      = i_req_valid && o_req_ready;

    // Next-state, command capture and load extraction.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rd_en_d  = rd_en_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    funct3_d = i_req_funct3;
                    offset_d = i_req_addr[1:0];
                    rdata_d  = '0;
                    fault_d  = req_fault;
                    if (req_fault) begin
                        state_d = S_RESP;
                    end else begin
                        addr_d  = i_req_addr[WORD_ADDR_WIDTH+1:2];
                        rd_en_d = !i_req_write;
                        if (i_req_write) begin
                            wstrb_d = store_strobe(i_req_funct3, i_req_addr[1:0]);
                            wdata_d = store_lanes(i_req_funct3, i_req_wdata);
                        end else begin
                            wstrb_d = '0;
                        end
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = rd_en_q ? S_WAIT : S_RESP;
            S_WAIT: begin
                rdata_d = load_extend(funct3_q, offset_q, i_mem_read_data);
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and command/response registers; clk_en freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rd_en_q  <= 1'b0;
            funct3_q <= '0;
            offset_q <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rd_en_q  <= rd_en_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign o_mem_read_enable  = (state_q == S_ISSUE) && rd_en_q;
    assign o_mem_write_enable = (state_q == S_ISSUE) ? wstrb_q : '0;
    assign o_mem_read_addr    = addr_q;
    assign o_mem_write_addr   = addr_q;
    assign o_mem_write_data   = wdata_q;

    assign o_resp_valid = (state_q == S_RESP);
    assign o_resp_rdata = rdata_q;
    assign o_resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small registered-read RAM model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_fault;
    logic        o_mem_read_enable;
    logic [10:0] o_mem_read_addr;
    logic [31:0] i_mem_read_data;
    logic [3:0]  o_mem_write_enable;
    logic [10:0] o_mem_write_addr;
    logic [31:0] o_mem_write_data;

    int checks = 0;
    int errors = 0;
    int en_count = 0;

    logic [31:0] mem [0:2047];

    load_store_unit #(.WORD_ADDR_WIDTH(11)) dut (
        .clk                (clk),
        .rst                (rst),
        .clk_en             (clk_en),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_write        (i_req_write),
        .i_req_funct3       (i_req_funct3),
        .i_req_addr         (i_req_addr),
        .i_req_wdata        (i_req_wdata),
        .o_resp_valid       (o_resp_valid),
        .o_resp_rdata       (o_resp_rdata),
        .o_resp_fault       (o_resp_fault),
        .o_mem_read_enable  (o_mem_read_enable),
        .o_mem_read_addr    (o_mem_read_addr),
        .i_mem_read_data    (i_mem_read_data),
        .o_mem_write_enable (o_mem_write_enable),
        .o_mem_write_addr   (o_mem_write_addr),
        .o_mem_write_data   (o_mem_write_data)
    );

    always #5 clk = ~clk;

    // RAM model: byte-strobed writes, registered read, shares clk_en, ignores rst.
    always @(posedge clk) begin
        if (clk_en) begin
            for (int b = 0; b < 4; b++) begin
                if (o_mem_write_enable[b]) mem[o_mem_write_addr][8*b +: 8] <= o_mem_write_data[8*b +: 8];
            end
            if (o_mem_read_enable) i_mem_read_data <= mem[o_mem_read_addr];
        end
    end

    // Counts edges where any RAM enable is asserted.
    always @(posedge clk) begin
        if (o_mem_read_enable || (o_mem_write_enable != 4'b0000)) en_count <= en_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; checks cycle-1 RAM command (if cmd) and the response.
    task automatic txn(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int freeze,
                       input int exp_cycle, input logic [31:0] exp_rdata, input logic exp_fault,
                       input logic cmd, input logic [3:0] exp_we, input logic [31:0] exp_wdata);
        int budget;
        int n;
        budget = 0;
        while (!o_req_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check({name, "_ready"}, {31'b0, o_req_ready}, 32'd1);
        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        n = 1;
        if (cmd) begin
            check({name, "_we"}, {28'b0, o_mem_write_enable}, {28'b0, exp_we});
            check({name, "_re"}, {31'b0, o_mem_read_enable}, {31'b0, !wr});
            check({name, "_waddr"}, {21'b0, o_mem_write_addr}, {21'b0, addr[12:2]});
            check({name, "_raddr"}, {21'b0, o_mem_read_addr}, {21'b0, addr[12:2]});
            if (wr) check({name, "_wdata"}, o_mem_write_data, exp_wdata);
        end
        while (!o_resp_valid && n < 12) begin
            if (freeze != 0 && n == freeze) clk_en = 1'b0;
            if (freeze != 0 && n == freeze + 2) clk_en = 1'b1;
            if (!clk_en) begin
                check({name, "_frozen_ready"}, {31'b0, o_req_ready}, 32'd0);
                check({name, "_frozen_re"}, {31'b0, o_mem_read_enable}, 32'd0);
            end
            @(posedge clk); #1;
            n++;
        end
        check({name, "_cycle"}, o_resp_valid ? n : -1, exp_cycle);
        check({name, "_rdata"}, o_resp_rdata, exp_rdata);
        check({name, "_fault"}, {31'b0, o_resp_fault}, {31'b0, exp_fault});
    endtask

    initial begin
        int en_before;
        int seen;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        i_mem_read_data = 32'h0;
        rst = 1'b1;
        clk_en = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_funct3 = 3'b000;
        i_req_addr = 32'h0;
        i_req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        check("rst_resp_fault", {31'b0, o_resp_fault}, 32'd0);
        check("rst_resp_rdata", o_resp_rdata, 32'h0);
        check("rst_re", {31'b0, o_mem_read_enable}, 32'd0);
        check("rst_we", {28'b0, o_mem_write_enable}, 32'd0);
        check("rst_raddr", {21'b0, o_mem_read_addr}, 32'd0);
        check("rst_waddr", {21'b0, o_mem_write_addr}, 32'd0);
        check("rst_wdata", o_mem_write_data, 32'h0);
        check("rst_ready", {31'b0, o_req_ready}, 32'd1);

        // Stores then loads of word 4.
        txn("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 2, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF);
        txn("sb13",  1'b1, 3'b000, 32'h13, 32'h000000A5, 0, 2, 32'h0, 1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5);
        txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 0, 3, 32'hA5ADBEEF, 1'b0, 1'b1, 4'b0000, 32'h0);
        txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 0, 3, 32'hFFFFFFA5, 1'b0, 1'b1, 4'b0000, 32'h0);
        txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 0, 3, 32'h000000A5, 1'b0, 1'b1, 4'b0000, 32'h0);
        txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 0, 3, 32'hFFFFA5AD, 1'b0, 1'b1, 4'b0000, 32'h0);
        txn("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 0, 3, 32'h0000BEEF, 1'b0, 1'b1, 4'b0000, 32'h0);
        txn("sh12",  1'b1, 3'b001, 32'h12, 32'hFFFF1234, 0, 2, 32'h0, 1'b0, 1'b1, 4'b1100, 32'h12341234);
        txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 0, 3, 32'h00001234, 1'b0, 1'b1, 4'b0000, 32'h0);
        // Highest legal word.
        txn("sw1ffc", 1'b1, 3'b010, 32'h1FFC, 32'h89ABCDEF, 0, 2, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h89ABCDEF);
        txn("lb1ffd", 1'b0, 3'b000, 32'h1FFD, 32'h0, 0, 3, 32'hFFFFFFCD, 1'b0, 1'b1, 4'b0000, 32'h0);

        // Faults: no RAM enable may be seen.
        @(posedge clk); #1;
        en_before = en_count;
        txn("f_lw12",   1'b0, 3'b010, 32'h12,   32'h0, 0, 1, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        txn("f_sh11",   1'b1, 3'b001, 32'h11,   32'h0, 0, 1, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        txn("f_ld011",  1'b0, 3'b011, 32'h10,   32'h0, 0, 1, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        txn("f_lw2000", 1'b0, 3'b010, 32'h2000, 32'h0, 0, 1, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        txn("f_st100",  1'b1, 3'b100, 32'h10,   32'h0, 0, 1, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        txn("f_lhu11",  1'b0, 3'b101, 32'h11,   32'h0, 0, 1, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
        @(posedge clk); #1;
        check("fault_no_ram_enable", en_count, en_before);

        // clk_en low for 2 cycles in WAIT delays the response by 2.
        txn("lw_freeze", 1'b0, 3'b010, 32'h10, 32'h0, 2, 5, 32'h1234BEEF, 1'b0, 1'b1, 4'b0000, 32'h0);

        // Reset during WAIT abandons the load.
        @(posedge clk); #1;
        i_req_valid  = 1'b1;
        i_req_write  = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h1FFC;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", {31'b0, o_req_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (o_resp_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_resp", seen, 0);
        check("rst_mid_rdata", o_resp_rdata, 32'h0);
        txn("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 0, 3, 32'h1234BEEF, 1'b0, 1'b1, 4'b0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case the design stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
